// File: rtl/ysyx_22050612_ifu.sv
// Instruction fetch unit: owns the PC, issues one 64-bit fetch at a time and
// hands 32-bit instructions to decode, discarding fetches made stale by a redirect.
module ysyx_22050612_ifu #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [63:0] req_addr,
    input  logic        rsp_valid,
    input  logic [63:0] rsp_data,
    input  logic        rsp_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [63:0] inst_pc,
    output logic        inst_err,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc
);

    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;
    localparam logic [ILEN-1:0] NOP_INST = ILEN'(32'h0000_0013);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_OUT,
        S_DROP
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [ILEN-1:0]   inst_q, inst_d;
    logic [XLEN-1:0]   inst_pc_q, inst_pc_d;
    logic              inst_err_q, inst_err_d;
    logic              req_valid_q;
    logic              inst_valid_q;

    logic              req_fire_c;
    logic [XLEN-1:0]   redirect_tgt_c;
    logic [ILEN-1:0]   rsp_word_c;

    assign req_fire_c     = req_valid_q & req_ready;
    assign redirect_tgt_c = {redirect_pc[XLEN-1:2], 2'b00};
    assign rsp_word_c     = pc_q[2] ? rsp_data[63:32] : rsp_data[31:0];

    // Next-state and datapath update; redirect overrides every other transition.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        inst_pc_d  = inst_pc_q;
        inst_err_d = inst_err_q;
        unique case (state_q)
            S_REQ: begin
                if (redirect_valid) begin
                    pc_d    = redirect_tgt_c;
                    state_d = req_fire_c ? S_DROP : S_REQ;
                end else if (req_fire_c) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    pc_d    = redirect_tgt_c;
                    state_d = rsp_valid ? S_REQ : S_DROP;
                end else if (rsp_valid) begin
                    inst_d     = rsp_err ? NOP_INST : rsp_word_c;
                    inst_err_d = rsp_err;
                    inst_pc_d  = pc_q;
                    state_d    = S_OUT;
                end
            end
            S_OUT: begin
                if (redirect_valid) begin
                    pc_d    = redirect_tgt_c;
                    state_d = S_REQ;
                end else if (inst_ready) begin
                    pc_d    = pc_q + XLEN'(4);
                    state_d = S_REQ;
                end
            end
            S_DROP: begin
                if (redirect_valid) begin
                    pc_d = redirect_tgt_c;
                end
                if (rsp_valid) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    // Valid flags follow the next state so they are clean flop outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            inst_err_q   <= 1'b0;
            req_valid_q  <= 1'b0;
            inst_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_err_q   <= inst_err_d;
            req_valid_q  <= (state_d == S_REQ);
            inst_valid_q <= (state_d == S_OUT);
        end
    end

    assign req_valid  = req_valid_q;
    assign req_addr   = {pc_q[XLEN-1:3], 3'b000};
    assign inst_valid = inst_valid_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign inst_err   = inst_err_q;

endmodule

// File: tb/tb_ysyx_22050612_ifu.sv
// Bench for the fetch unit: directed vectors for the listed corner cases, then
// random traffic checked against an architectural-PC model of the fetch stream.
module tb_ysyx_22050612_ifu;

    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready;
    logic [63:0] req_addr;
    logic        rsp_valid, rsp_err;
    logic [63:0] rsp_data;
    logic        inst_valid, inst_ready, inst_err;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        redirect_valid;
    logic [63:0] redirect_pc;

    ysyx_22050612_ifu #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .rsp_err        (rsp_err),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_err       (inst_err),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
        logic        err;
        logic [31:0] exp_inst;
        logic [63:0] exp_pc;
        logic        exp_err;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!req_valid && n < 20) begin
            tick();
            n++;
        end
        chk("req_valid_wait", 64'(req_valid), 64'd1);
    endtask

    // Issue one fetch and return it, leaving the DUT presenting the instruction.
    task automatic fetch_to_out(input logic [63:0] addr, input logic [63:0] data, input logic err);
        wait_req();
        chk("req_addr", req_addr, addr);
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        chk("req_valid_in_wait", 64'(req_valid), 64'd0);
        rsp_valid = 1'b1;
        rsp_data  = data;
        rsp_err   = err;
        tick();
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        chk("inst_valid_out", 64'(inst_valid), 64'd1);
    endtask

    task automatic apply_vec(input vec_t v);
        fetch_to_out(v.addr, v.data, v.err);
        chk("inst", 64'(inst), 64'(v.exp_inst));
        chk("inst_pc", inst_pc, v.exp_pc);
        chk("inst_err", 64'(inst_err), 64'(v.exp_err));
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        chk("inst_valid_drop", 64'(inst_valid), 64'd0);
    endtask

    // Memory image for the random phase: a pure function of the doubleword address.
    function automatic logic [63:0] mem_fn(input logic [63:0] a);
        return {a[31:0] ^ a[63:32] ^ 32'h1234_5678, ~a[31:0]};
    endfunction

    function automatic logic err_fn(input logic [63:0] a);
        return a[7:3] == 5'h0B;
    endfunction

    function automatic logic [31:0] exp_inst_fn(input logic [63:0] pc);
        logic [63:0] a;
        logic [63:0] d;
        a = {pc[63:3], 3'b000};
        d = mem_fn(a);
        if (err_fn(a)) return NOP_INST;
        return pc[2] ? d[63:32] : d[31:0];
    endfunction

    logic [63:0] model_pc, maddr, tgt, a_s;
    logic        outstanding, f_req, f_rsp, f_inst, redir;
    int          cd, n_deliv;
    logic [31:0] hold_inst;
    logic [63:0] hold_pc;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{64'h8000_0000, 64'h0010_0073_0000_0513, 1'b0, 32'h0000_0513, 64'h8000_0000, 1'b0};
        vecs[1] = '{64'h8000_0000, 64'h0010_0073_0000_0513, 1'b0, 32'h0010_0073, 64'h8000_0004, 1'b0};
        vecs[2] = '{64'h8000_0008, 64'hDEAD_BEEF_CAFE_F00D, 1'b1, NOP_INST,      64'h8000_0008, 1'b1};
        vecs[3] = '{64'h8000_0008, 64'h00A0_0093_1111_2222, 1'b0, 32'h00A0_0093, 64'h8000_000C, 1'b0};

        rst_n = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0; rsp_err = 1'b0;
        inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        tick(); tick();
        chk("rst_req_valid", 64'(req_valid), 64'd0);
        chk("rst_inst_valid", 64'(inst_valid), 64'd0);
        chk("rst_inst", 64'(inst), 64'd0);
        chk("rst_inst_pc", inst_pc, 64'd0);
        chk("rst_inst_err", 64'(inst_err), 64'd0);
        rst_n = 1'b1;
        chk("req_valid_before_edge", 64'(req_valid), 64'd0);
        tick();
        chk("req_valid_first", 64'(req_valid), 64'd1);

        for (int i = 0; i < 4; i++) apply_vec(vecs[i]);

        // Decode stall: outputs frozen, no new request.
        fetch_to_out(64'h8000_0010, 64'h0000_0001_0000_0002, 1'b0);
        hold_inst = inst;
        hold_pc   = inst_pc;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_valid", 64'(inst_valid), 64'd1);
            chk("stall_inst", 64'(inst), 64'(hold_inst));
            chk("stall_pc", inst_pc, hold_pc);
            chk("stall_no_req", 64'(req_valid), 64'd0);
        end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;

        // Redirect while waiting; the late response must be discarded.
        wait_req();
        chk("req_addr_pre_redir", req_addr, 64'h8000_0010);
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0100;
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("drop_no_inst", 64'(inst_valid), 64'd0);
            chk("drop_no_req", 64'(req_valid), 64'd0);
            tick();
        end
        rsp_valid = 1'b1;
        rsp_data  = 64'hBAD0_BAD0_BAD0_BAD0;
        tick();
        rsp_valid = 1'b0;
        chk("stale_not_shown", 64'(inst_valid), 64'd0);
        apply_vec('{64'h8000_0100, 64'h0000_0AAA_0000_0BBB, 1'b0, 32'h0000_0BBB, 64'h8000_0100, 1'b0});

        // Handshake and misaligned redirect in the same cycle.
        fetch_to_out(64'h8000_0100, 64'h0000_0CCC_0000_0DDD, 1'b0);
        chk("pre_redir_inst", 64'(inst), 64'h0000_0CCC);
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0022;
        tick();
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        apply_vec('{64'h8000_0020, 64'h0000_0EEE_0000_0FFF, 1'b0, 32'h0000_0FFF, 64'h8000_0020, 1'b0});

        // Asynchronous reset while presenting an instruction.
        fetch_to_out(64'h8000_0020, 64'h0000_0123_0000_0456, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_inst_valid", 64'(inst_valid), 64'd0);
        chk("async_rst_inst_pc", inst_pc, 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        tick();

        // Asynchronous reset while waiting; fetch restarts at the reset PC.
        wait_req();
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_wait_req", 64'(req_valid), 64'd0);
        chk("async_rst_wait_inst", 64'(inst_valid), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        apply_vec(vecs[0]);

        // Random phase against the architectural PC model.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_pc = RESET_PC;
        outstanding = 1'b0;
        maddr = '0;
        cd = 0;
        n_deliv = 0;
        for (int c = 0; c < 4000; c++) begin
            f_req  = req_valid & req_ready;
            f_rsp  = rsp_valid;
            f_inst = inst_valid & inst_ready;
            redir  = redirect_valid;
            tgt    = redirect_pc;
            a_s    = req_addr;
            if (f_inst) begin
                chk("rnd_inst_pc", inst_pc, model_pc);
                chk("rnd_inst", 64'(inst), 64'(exp_inst_fn(model_pc)));
                chk("rnd_inst_err", 64'(inst_err), 64'(err_fn({model_pc[63:3], 3'b000})));
                n_deliv++;
            end
            if (f_req) begin
                chk("rnd_one_outstanding", 64'(outstanding), 64'd0);
                chk("rnd_req_addr", a_s, {model_pc[63:3], 3'b000});
            end
            tick();
            if (redir) model_pc = {tgt[63:2], 2'b00};
            else if (f_inst) model_pc = model_pc + 64'd4;
            if (f_rsp) outstanding = 1'b0;
            if (f_req) begin
                outstanding = 1'b1;
                maddr = a_s;
                cd = $urandom_range(0, 2);
            end else if (outstanding && cd > 0) begin
                cd--;
            end
            rsp_valid = outstanding && (cd == 0);
            rsp_data  = mem_fn(maddr);
            rsp_err   = err_fn(maddr);
            req_ready  = ($urandom_range(0, 3) != 0);
            inst_ready = ($urandom_range(0, 1) != 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) == 0) redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
            else redirect_pc = 64'h8000_0000 + 64'($urandom_range(0, 4095));
        end
        chk("rnd_progress", 64'(n_deliv >= 50), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
